// File: rtl/id_decode_pkg.sv
// rtl/id_decode_pkg.sv - opcode constants, format classes and width defaults for the ID stage
package id_decode_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;

endpackage

// File: rtl/id_decode_stage_imm_gen.sv
// rtl/id_decode_stage_imm_gen.sv - combinational immediate generator, sign-extended to XLEN
module id_imm_gen
  import id_decode_pkg::*;
#(
  parameter int XLEN = DATA_WIDTH_DEF
) (
  input  logic [31:7]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_ext;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed-to-signed assignment carries bit 31 up to XLEN.
    imm_ext = imm32;
    imm     = imm_ext;
  end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - registered RISC-V decode stage with valid/ready, stall and flush
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int XLEN           = DATA_WIDTH_DEF,
  parameter int PC_WIDTH       = 32,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int SEQ_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic [31:0]               in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [31:0]               out_instr,
  output logic [REG_ADDR_WIDTH-1:0] raddr1,
  output logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic [REG_ADDR_WIDTH-1:0] waddr,
  output logic [2:0]                func3,
  output logic [6:0]                func7,
  output logic [6:0]                opcode,
  output logic [XLEN-1:0]           imm,
  output logic [2:0]                fmt,
  output logic                      rs1_used,
  output logic                      rs2_used,
  output logic                      rd_we,
  output logic                      illegal,
  output logic [SEQ_WIDTH-1:0]      seq_id
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]  pc;
    logic [31:0]          instr;
    logic [XLEN-1:0]      imm;
    fmt_e                 fmt;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 rd_we;
    logic                 illegal;
    logic [SEQ_WIDTH-1:0] seq;
  } bundle_t;

  logic                 valid_q, valid_d;
  bundle_t              bundle_q, bundle_d, dec;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 accept;
  fmt_e                 fmt_c, fmt_dec;
  logic                 known, rs1_u, rs2_u, rd_u, bad_reg, ill_c;
  logic [4:0]           rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0]      imm_c;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign rs1_f    = in_instr[19:15];
  assign rs2_f    = in_instr[24:20];
  assign rd_f     = in_instr[11:7];

  always_comb begin
    fmt_c = FMT_R;
    known = 1'b1;
    case (in_instr[6:0])
      OPC_LUI, OPC_AUIPC:  fmt_c = FMT_U;
      OPC_JAL:             fmt_c = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM:
                           fmt_c = FMT_I;
      OPC_BRANCH:          fmt_c = FMT_B;
      OPC_STORE:           fmt_c = FMT_S;
      OPC_OP:              fmt_c = FMT_R;
      OPC_OP_IMM32: begin
        if (XLEN == 64) fmt_c = FMT_I;
        else            known = 1'b0;
      end
      OPC_OP_32: begin
        if (XLEN == 64) fmt_c = FMT_R;
        else            known = 1'b0;
      end
      default:             known = 1'b0;
    endcase

    rs1_u = fmt_c inside {FMT_R, FMT_I, FMT_S, FMT_B};
    rs2_u = fmt_c inside {FMT_R, FMT_S, FMT_B};
    rd_u  = fmt_c inside {FMT_R, FMT_I, FMT_U, FMT_J};

    // RV32E only has x0..x15; a used index reaching x16+ cannot be encoded.
    bad_reg = 1'b0;
    if (REG_ADDR_WIDTH == 4)
      bad_reg = (rs1_u && rs1_f[4]) || (rs2_u && rs2_f[4]) || (rd_u && rd_f[4]);

    ill_c   = (in_instr[1:0] != 2'b11) || !known || bad_reg;
    fmt_dec = ill_c ? FMT_R : fmt_c;
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt_dec),
    .imm   (imm_c)
  );

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.imm      = imm_c;
    dec.fmt      = fmt_dec;
    dec.rs1_used = rs1_u && !ill_c;
    dec.rs2_used = rs2_u && !ill_c;
    dec.rd_we    = rd_u && (rd_f != 5'd0) && !ill_c;
    dec.illegal  = ill_c;
    dec.seq      = seq_q;
  end

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    seq_d    = seq_q;
    // The tag advances on every handshake, even one that a flush discards.
    if (accept) seq_d = seq_q + SEQ_WIDTH'(1);
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      seq_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      seq_q    <= seq_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = bundle_q.pc;
  assign out_instr = bundle_q.instr;
  assign raddr1    = bundle_q.instr[15 +: REG_ADDR_WIDTH];
  assign raddr2    = bundle_q.instr[20 +: REG_ADDR_WIDTH];
  assign waddr     = bundle_q.instr[7 +: REG_ADDR_WIDTH];
  assign func3     = bundle_q.instr[14:12];
  assign func7     = bundle_q.instr[31:25];
  assign opcode    = bundle_q.instr[6:0];
  assign imm       = bundle_q.imm;
  assign fmt       = bundle_q.fmt;
  assign rs1_used  = bundle_q.rs1_used;
  assign rs2_used  = bundle_q.rs2_used;
  assign rd_we     = bundle_q.rd_we;
  assign illegal   = bundle_q.illegal;
  assign seq_id    = bundle_q.seq;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - scoreboard bench for id_decode_stage in RV32I, RV64I and RV32E builds
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic [2:0]  flags;
    logic        ill;
    logic [2:0]  fmt64;
    logic [63:0] imm64;
    logic [2:0]  flags64;
    logic        ill64;
    logic        ill_e;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    logic [7:0]  seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        in_ready_a, out_valid_a, rs1_used_a, rs2_used_a, rd_we_a, illegal_a;
  logic [31:0] out_pc_a, out_instr_a, imm_a;
  logic [4:0]  raddr1_a, raddr2_a, waddr_a;
  logic [2:0]  func3_a, fmt_a;
  logic [6:0]  func7_a, opcode_a;
  logic [7:0]  seq_a;

  logic        in_ready_w, out_valid_w, rs1_used_w, rs2_used_w, rd_we_w, illegal_w;
  logic [31:0] out_pc_w, out_instr_w;
  logic [63:0] imm_w;
  logic [4:0]  raddr1_w, raddr2_w, waddr_w;
  logic [2:0]  func3_w, fmt_w;
  logic [6:0]  func7_w, opcode_w;
  logic [7:0]  seq_w;

  logic        in_ready_e, out_valid_e, rs1_used_e, rs2_used_e, rd_we_e, illegal_e;
  logic [31:0] out_pc_e, out_instr_e, imm_e;
  logic [3:0]  raddr1_e, raddr2_e, waddr_e;
  logic [2:0]  func3_e, fmt_e_o;
  logic [6:0]  func7_e, opcode_e;
  logic [7:0]  seq_e;

  id_decode_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_pc(out_pc_a), .out_instr(out_instr_a), .raddr1(raddr1_a), .raddr2(raddr2_a),
    .waddr(waddr_a), .func3(func3_a), .func7(func7_a), .opcode(opcode_a), .imm(imm_a),
    .fmt(fmt_a), .rs1_used(rs1_used_a), .rs2_used(rs2_used_a), .rd_we(rd_we_a),
    .illegal(illegal_a), .seq_id(seq_a)
  );

  id_decode_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_pc(out_pc_w), .out_instr(out_instr_w), .raddr1(raddr1_w), .raddr2(raddr2_w),
    .waddr(waddr_w), .func3(func3_w), .func7(func7_w), .opcode(opcode_w), .imm(imm_w),
    .fmt(fmt_w), .rs1_used(rs1_used_w), .rs2_used(rs2_used_w), .rd_we(rd_we_w),
    .illegal(illegal_w), .seq_id(seq_w)
  );

  id_decode_stage #(.REG_ADDR_WIDTH(4)) u_dute (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_e),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid_e), .out_ready(out_ready),
    .out_pc(out_pc_e), .out_instr(out_instr_e), .raddr1(raddr1_e), .raddr2(raddr2_e),
    .waddr(waddr_e), .func3(func3_e), .func7(func7_e), .opcode(opcode_e), .imm(imm_e),
    .fmt(fmt_e_o), .rs1_used(rs1_used_e), .rs2_used(rs2_used_e), .rd_we(rd_we_e),
    .illegal(illegal_e), .seq_id(seq_e)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          stall_waits = 0;
  vec_t        vecs[15];
  exp_t        sb[$];
  logic [31:0] pc_tb = 32'h0000_1000;
  logic [7:0]  seq_tb = 8'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Decoupled checker: every beat the DUT hands downstream is matched to the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    vec_t v;
    if (rst_n && out_valid_a && (flush || out_ready)) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(sb.size()), 64'(1));
      end else begin
        e = sb.pop_front();
        v = e.v;
        if (!flush) begin
          chk("a_pc_instr", {out_pc_a, out_instr_a}, {e.pc, v.instr});
          chk("a_fields", 64'({raddr1_a, raddr2_a, waddr_a, func3_a, func7_a, opcode_a}),
              64'({v.instr[19:15], v.instr[24:20], v.instr[11:7], v.instr[14:12], v.instr[31:25], v.instr[6:0]}));
          chk("a_fmt", 64'(fmt_a), 64'(v.fmt));
          chk("a_imm", 64'(imm_a), 64'(v.imm32));
          chk("a_flags", 64'({rd_we_a, rs1_used_a, rs2_used_a}), 64'(v.flags));
          chk("a_illegal", 64'(illegal_a), 64'(v.ill));
          chk("a_seq", 64'(seq_a), 64'(e.seq));
          chk("aux_handshake", 64'({out_valid_w, out_valid_e, in_ready_w, in_ready_e}), 64'(4'b1111));
          chk("w_pc_instr_seq", {out_pc_w, out_instr_w ^ {24'd0, seq_w}}, {e.pc, v.instr ^ {24'd0, e.seq}});
          chk("w_fields", 64'({raddr1_w, raddr2_w, waddr_w, func3_w, func7_w, opcode_w}),
              64'({v.instr[19:15], v.instr[24:20], v.instr[11:7], v.instr[14:12], v.instr[31:25], v.instr[6:0]}));
          chk("w_fmt", 64'(fmt_w), 64'(v.fmt64));
          chk("w_imm", imm_w, v.imm64);
          chk("w_flags", 64'({rd_we_w, rs1_used_w, rs2_used_w}), 64'(v.flags64));
          chk("w_illegal", 64'(illegal_w), 64'(v.ill64));
          chk("e_pc_instr_seq", {out_pc_e, out_instr_e ^ {24'd0, seq_e}}, {e.pc, v.instr ^ {24'd0, e.seq}});
          chk("e_fields", 64'({raddr1_e, raddr2_e, waddr_e, func3_e, func7_e, opcode_e}),
              64'({v.instr[18:15], v.instr[23:20], v.instr[10:7], v.instr[14:12], v.instr[31:25], v.instr[6:0]}));
          chk("e_illegal", 64'(illegal_e), 64'(v.ill_e));
          chk("e_fmt_imm", {29'd0, fmt_e_o, imm_e}, {29'd0, v.ill_e ? 3'd0 : v.fmt, v.ill_e ? 32'd0 : v.imm32});
          chk("e_flags", 64'({rd_we_e, rs1_used_e, rs2_used_e}), 64'(v.ill_e ? 3'b000 : v.flags));
        end
      end
    end
  end

  task automatic send(input int idx, input bit do_flush);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = pc_tb;
    flush    = do_flush;
    @(negedge clk);
    while (!in_ready_a && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    chk("accept_ready", 64'(in_ready_a), 64'(1));
    stall_waits += waits;
    if (in_ready_a) begin
      if (!do_flush) sb.push_back('{v: vecs[idx], pc: pc_tb, seq: seq_tb});
      seq_tb++;
    end
    pc_tb += 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 3'd1, 32'h00000005, 3'b110, 1'b0, 3'd1, 64'h5,                  3'b110, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE208EE3, 3'd3, 32'hFFFFFFFC, 3'b011, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC,   3'b011, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000000, 3'd0, 32'h00000000, 3'b000, 1'b1, 3'd0, 64'h0,                  3'b000, 1'b1, 1'b1};
    vecs[3]  = '{32'hFFFFFFFF, 3'd0, 32'h00000000, 3'b000, 1'b1, 3'd0, 64'h0,                  3'b000, 1'b1, 1'b1};
    vecs[4]  = '{32'h00080093, 3'd1, 32'h00000000, 3'b110, 1'b0, 3'd1, 64'h0,                  3'b110, 1'b0, 1'b1};
    vecs[5]  = '{32'h00000813, 3'd1, 32'h00000000, 3'b110, 1'b0, 3'd1, 64'h0,                  3'b110, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000009B, 3'd0, 32'h00000000, 3'b000, 1'b1, 3'd1, 64'h0,                  3'b110, 1'b0, 1'b1};
    vecs[7]  = '{32'h800000B7, 3'd4, 32'h80000000, 3'b100, 1'b0, 3'd4, 64'hFFFFFFFF80000000,   3'b100, 1'b0, 1'b0};
    vecs[8]  = '{32'h0020A423, 3'd2, 32'h00000008, 3'b011, 1'b0, 3'd2, 64'h8,                  3'b011, 1'b0, 1'b0};
    vecs[9]  = '{32'hFF9FF0EF, 3'd5, 32'hFFFFFFF8, 3'b100, 1'b0, 3'd5, 64'hFFFFFFFFFFFFFFF8,   3'b100, 1'b0, 1'b0};
    vecs[10] = '{32'h002081B3, 3'd0, 32'h00000000, 3'b111, 1'b0, 3'd0, 64'h0,                  3'b111, 1'b0, 1'b0};
    vecs[11] = '{32'h00001017, 3'd4, 32'h00001000, 3'b000, 1'b0, 3'd4, 64'h1000,               3'b000, 1'b0, 1'b0};
    vecs[12] = '{32'h002080BB, 3'd0, 32'h00000000, 3'b000, 1'b1, 3'd0, 64'h0,                  3'b111, 1'b0, 1'b1};
    vecs[13] = '{32'hFFF08093, 3'd1, 32'hFFFFFFFF, 3'b110, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF,   3'b110, 1'b0, 1'b0};
    vecs[14] = '{32'h00000001, 3'd0, 32'h00000000, 3'b000, 1'b1, 3'd0, 64'h0,                  3'b000, 1'b1, 1'b1};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_pc     = '0;
    in_instr  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'({out_valid_a, out_valid_w, out_valid_e}), 64'(0));
    chk("reset_data", {out_instr_a, imm_a}, 64'(0));
    chk("reset_seq_pc", 64'({seq_a, out_pc_a}), 64'(0));
    chk("reset_in_ready", 64'(in_ready_a), 64'(1));
    rst_n = 1'b1;

    // Back-to-back stream covering every format and the illegal cases.
    stall_waits = 0;
    for (int i = 0; i < 15; i++) send(i, 1'b0);
    chk("full_throughput_waits", 64'(stall_waits), 64'(0));
    drain();

    // Backpressure: held bundle must stay put while the next beat waits.
    out_ready = 1'b0;
    send(0, 1'b0);
    in_valid = 1'b1;
    in_instr = vecs[1].instr;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready_a), 64'(0));
      chk("stall_out_valid", 64'(out_valid_a), 64'(1));
      chk("stall_hold", 64'({out_instr_a, imm_a}), {vecs[0].instr, vecs[0].imm32});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1, 1'b0);
    drain();

    // Flush kills both the held and the incoming beat; the tag still moves on.
    send(2, 1'b0);
    send(3, 1'b1);
    chk("flush_kill", 64'({out_valid_a, out_valid_w, out_valid_e}), 64'(0));
    send(10, 1'b0);
    drain();

    // Asynchronous reset in the middle of a valid beat.
    send(7, 1'b0);
    chk("pre_reset_valid", 64'(out_valid_a), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'({out_valid_a, out_valid_w, out_valid_e}), 64'(0));
    chk("async_reset_seq", 64'({seq_a, out_instr_a}), 64'(0));
    sb.delete();
    seq_tb = 8'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8, 1'b0);
    send(9, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
